opcode_prefix_scanner: RTL
==========================

Name: opcode_prefix_scanner

Overview:
- Byte-serial front end of the x86-64 decoder. Sits between the fetch byte stream and the opcode-info lookup stage.
- Strips legacy and REX prefixes and resolves the 0F / 0F38 / 0F3A escapes.
- Delivers {opcode byte, map, prefix summary, length} so the downstream stage can index the one-byte table (map 0) or the two-byte table (map 1).

Parameters:
- MAX_LEN, 15, architectural instruction-length limit in bytes; reaching it before the opcode byte arrives raises an error.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  synchronous redirect; discards partial scan and any held output
- in_byte  in  8  next instruction byte from fetch
- in_valid  in  1  in_byte is valid
- in_ready  out  1  scanner accepts in_byte this cycle
- out_valid  out  1  decoded opcode record valid
- out_ready  in  1  downstream accepts record
- out_opcode  out  8  opcode byte (index into the map's info table)
- out_map  out  2  0 = one-byte, 1 = 0F, 2 = 0F38, 3 = 0F3A
- out_lock  out  1  F0 seen
- out_rep  out  2  00 none, 01 F3, 10 F2
- out_opsz  out  1  66 seen
- out_adsz  out  1  67 seen
- out_seg  out  3  0 none, 1 ES, 2 CS, 3 SS, 4 DS, 5 FS, 6 GS
- out_rex  out  5  {present, W, R, X, B}
- out_len  out  4  bytes consumed, including the opcode byte
- out_err  out  1  length-limit violation

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state = PFX
  - out_valid, in_ready (first cycle), and all out_* fields = 0
  - internal prefix accumulators and byte count = 0
  - in_ready rises on the first cycle after reset deasserts.
- A byte is accepted on a cycle where in_valid && in_ready. Each accepted byte increments cnt, a 4-bit counter.
- in_ready = (state != HOLD). No byte is accepted while a record is held; there is one bubble per instruction.
- State PFX, on an accepted byte:
  - F0: set lock.
  - F2: rep = 10. F3: rep = 01. The last of F2/F3 wins.
  - 26/2E/36/3E/64/65: set seg. The last segment prefix wins.
  - 66: set opsz. 67: set adsz.
  - Any legacy prefix also clears the REX accumulator. REX only counts when it immediately precedes the opcode or escape.
  - 40-4F: rex = {1, byte[3:0]}. A later REX replaces an earlier one.
  - 0F: go to ESC.
  - Any other byte is the opcode: out_map = 0, go to HOLD.
- State ESC:
  - 38: go to ESC3 with map = 2.
  - 3A: go to ESC3 with map = 3.
  - Any other byte is the opcode: map = 1, go to HOLD.
- State ESC3: the next byte is the opcode; go to HOLD.
- On entering HOLD:
  - All out_* fields are registered from the accumulators.
  - out_len = cnt including the opcode byte.
  - out_valid = 1 on the following cycle.
  - Outputs stay stable until out_valid && out_ready.
- On the handshake in HOLD:
  - Clear the accumulators and cnt, then go to PFX.
  - in_ready returns to 1 the next cycle.
- Length limit:
  - If the accepted byte makes cnt == MAX_LEN and that byte is a prefix/escape (not an opcode), go to HOLD with out_err = 1, out_opcode = that byte, out_map = the current map, out_len = MAX_LEN.
  - An opcode arriving as exactly byte MAX_LEN is legal, with out_err = 0.
- flush:
  - Has priority over every other event, including a simultaneous handshake or byte acceptance.
  - Next state = PFX; accumulators, cnt and out_valid cleared; the byte accepted in the same cycle is dropped.
- Reset and flush behave identically except for reset's scope, which also covers the output fields.
- out_valid never drops without a handshake, except on flush or reset.
- Widths: cnt saturates logic at MAX_LEN; MAX_LEN must be ≤ 15.

Test Plan:
- Bytes 66 F3 48 0F AF -> one record: opcode AF, map 1, opsz 1, rep 01, rex 1_1000, len 5, err 0.
- Bytes 48 66 89 (REX then legacy prefix) -> opcode 89, map 0, rex 0_0000, opsz 1, len 3.
- Bytes 2E 64 F2 F3 90 -> seg 5 (FS), rep 01, opcode 90, len 5. Then hold out_ready = 0 for 4 cycles -> outputs stable and in_ready = 0 throughout.
- Bytes 0F 38 00 -> map 2, opcode 00, len 3. Then immediately 0F 3A 0F -> map 3, opcode 0F, len 3.
- 15 bytes of 66 -> out_err 1, out_len 15, out_opcode 66. With 14×66 then 90 -> err 0, len 15.
- Assert flush in the cycle after F0 0F is accepted, then send 90 -> opcode 90, map 0, lock 0, len 1. Assert reset_n = 0 while in HOLD -> out_valid 0 on the next cycle.

Source files
------------

// File: rtl/opcode_prefix_scanner.sv
// rtl/opcode_prefix_scanner.sv - x86-64 byte-serial prefix stripper and opcode-map resolver
module opcode_prefix_scanner #(
  parameter int unsigned MAX_LEN = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_opcode,
  output logic [1:0] out_map,
  output logic       out_lock,
  output logic [1:0] out_rep,
  output logic       out_opsz,
  output logic       out_adsz,
  output logic [2:0] out_seg,
  output logic [4:0] out_rex,
  output logic [3:0] out_len,
  output logic       out_err
);

  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    PFX  = 2'd0,
    ESC  = 2'd1,
    ESC3 = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Legacy prefix bytes: group 1 (lock/rep), group 2 (segment), group 3/4 (size overrides)
  function automatic logic is_legacy(input logic [7:0] b);
    case (b)
      8'hF0, 8'hF2, 8'hF3,
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'h67: is_legacy = 1'b1;
      default:      is_legacy = 1'b0;
    endcase
  endfunction

  function automatic logic is_rex(input logic [7:0] b);
    is_rex = (b[7:4] == 4'h4);
  endfunction

  // Scan state and prefix accumulators
  state_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] map_q, map_d;
  logic       lock_q, lock_d;
  logic [1:0] rep_q, rep_d;
  logic       opsz_q, opsz_d;
  logic       adsz_q, adsz_d;
  logic [2:0] seg_q, seg_d;
  logic [4:0] rex_q, rex_d;

  // Registered output record
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_opcode_q, out_opcode_d;
  logic [1:0] out_map_q, out_map_d;
  logic       out_lock_q, out_lock_d;
  logic [1:0] out_rep_q, out_rep_d;
  logic       out_opsz_q, out_opsz_d;
  logic       out_adsz_q, out_adsz_d;
  logic [2:0] out_seg_q, out_seg_d;
  logic [4:0] out_rex_q, out_rex_d;
  logic [3:0] out_len_q, out_len_d;
  logic       out_err_q, out_err_d;

  // Per-cycle decode helpers
  logic       accept;
  logic       handshake;
  logic [3:0] cnt_inc;
  logic       at_limit;
  logic       load;
  logic       load_err;
  logic [1:0] load_map;

  // Next-state, accumulator and output-record computation; flush overrides everything
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    map_d        = map_q;
    lock_d       = lock_q;
    rep_d        = rep_q;
    opsz_d       = opsz_q;
    adsz_d       = adsz_q;
    seg_d        = seg_q;
    rex_d        = rex_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_map_d    = out_map_q;
    out_lock_d   = out_lock_q;
    out_rep_d    = out_rep_q;
    out_opsz_d   = out_opsz_q;
    out_adsz_d   = out_adsz_q;
    out_seg_d    = out_seg_q;
    out_rex_d    = out_rex_q;
    out_len_d    = out_len_q;
    out_err_d    = out_err_q;
    load         = 1'b0;
    load_err     = 1'b0;
    load_map     = map_q;

    accept    = in_valid && in_ready_q;
    handshake = out_valid_q && out_ready;
    cnt_inc   = (cnt_q >= MAX_LEN_C) ? MAX_LEN_C : cnt_q + 4'd1;
    at_limit  = (cnt_inc == MAX_LEN_C);

    case (state_q)
      PFX: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (is_legacy(in_byte)) begin
            // A legacy prefix breaks REX adjacency to the opcode
            rex_d = 5'b0;
            case (in_byte)
              8'hF0:   lock_d = 1'b1;
              8'hF2:   rep_d  = 2'b10;
              8'hF3:   rep_d  = 2'b01;
              8'h26:   seg_d  = 3'd1;
              8'h2E:   seg_d  = 3'd2;
              8'h36:   seg_d  = 3'd3;
              8'h3E:   seg_d  = 3'd4;
              8'h64:   seg_d  = 3'd5;
              8'h65:   seg_d  = 3'd6;
              8'h66:   opsz_d = 1'b1;
              8'h67:   adsz_d = 1'b1;
              default: ;
            endcase
            if (at_limit) begin
              load     = 1'b1;
              load_err = 1'b1;
              load_map = map_q;
            end
          end else if (is_rex(in_byte)) begin
            rex_d = {1'b1, in_byte[3:0]};
            if (at_limit) begin
              load     = 1'b1;
              load_err = 1'b1;
              load_map = map_q;
            end
          end else if (in_byte == 8'h0F) begin
            if (at_limit) begin
              load     = 1'b1;
              load_err = 1'b1;
              load_map = map_q;
            end else begin
              map_d   = 2'd1;
              state_d = ESC;
            end
          end else begin
            load     = 1'b1;
            load_map = 2'd0;
          end
        end
      end

      ESC: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (in_byte == 8'h38 || in_byte == 8'h3A) begin
            if (at_limit) begin
              load     = 1'b1;
              load_err = 1'b1;
              load_map = map_q;
            end else begin
              map_d   = (in_byte == 8'h38) ? 2'd2 : 2'd3;
              state_d = ESC3;
            end
          end else begin
            load     = 1'b1;
            load_map = 2'd1;
          end
        end
      end

      ESC3: begin
        if (accept) begin
          cnt_d    = cnt_inc;
          load     = 1'b1;
          load_map = map_q;
        end
      end

      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          state_d     = PFX;
          cnt_d       = 4'd0;
          map_d       = 2'd0;
          lock_d      = 1'b0;
          rep_d       = 2'b0;
          opsz_d      = 1'b0;
          adsz_d      = 1'b0;
          seg_d       = 3'd0;
          rex_d       = 5'b0;
        end
      end

      default: state_d = PFX;
    endcase

    if (flush) begin
      state_d     = PFX;
      out_valid_d = 1'b0;
      cnt_d       = 4'd0;
      map_d       = 2'd0;
      lock_d      = 1'b0;
      rep_d       = 2'b0;
      opsz_d      = 1'b0;
      adsz_d      = 1'b0;
      seg_d       = 3'd0;
      rex_d       = 5'b0;
    end else if (load) begin
      // The record includes the prefix that tripped the limit, if any
      state_d      = HOLD;
      out_valid_d  = 1'b1;
      out_opcode_d = in_byte;
      out_map_d    = load_map;
      out_lock_d   = lock_d;
      out_rep_d    = rep_d;
      out_opsz_d   = opsz_d;
      out_adsz_d   = adsz_d;
      out_seg_d    = seg_d;
      out_rex_d    = rex_d;
      out_len_d    = cnt_d;
      out_err_d    = load_err;
    end

    in_ready_d = (state_d != HOLD);
  end

  // Single register bank for FSM, accumulators and output record
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= PFX;
      in_ready_q   <= 1'b0;
      cnt_q        <= 4'd0;
      map_q        <= 2'd0;
      lock_q       <= 1'b0;
      rep_q        <= 2'b0;
      opsz_q       <= 1'b0;
      adsz_q       <= 1'b0;
      seg_q        <= 3'd0;
      rex_q        <= 5'b0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= 8'h00;
      out_map_q    <= 2'd0;
      out_lock_q   <= 1'b0;
      out_rep_q    <= 2'b0;
      out_opsz_q   <= 1'b0;
      out_adsz_q   <= 1'b0;
      out_seg_q    <= 3'd0;
      out_rex_q    <= 5'b0;
      out_len_q    <= 4'd0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
      map_q        <= map_d;
      lock_q       <= lock_d;
      rep_q        <= rep_d;
      opsz_q       <= opsz_d;
      adsz_q       <= adsz_d;
      seg_q        <= seg_d;
      rex_q        <= rex_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_map_q    <= out_map_d;
      out_lock_q   <= out_lock_d;
      out_rep_q    <= out_rep_d;
      out_opsz_q   <= out_opsz_d;
      out_adsz_q   <= out_adsz_d;
      out_seg_q    <= out_seg_d;
      out_rex_q    <= out_rex_d;
      out_len_q    <= out_len_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_map    = out_map_q;
  assign out_lock   = out_lock_q;
  assign out_rep    = out_rep_q;
  assign out_opsz   = out_opsz_q;
  assign out_adsz   = out_adsz_q;
  assign out_seg    = out_seg_q;
  assign out_rex    = out_rex_q;
  assign out_len    = out_len_q;
  assign out_err    = out_err_q;

endmodule
